// File: rtl/music_pkg.sv
// Shared types and helpers for the tone arbitration slice.
package music_pkg;

  localparam logic [3:0]  NOTE_REST  = 4'd15;
  localparam int unsigned NUM_SRC    = 3;
  localparam logic [1:0]  OWNER_NONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_e;

  function automatic logic is_note(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd12);
  endfunction

  // (idx + step) mod 3 for idx, step in 0..2.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three sources, scanning from rr_ptr.
module rr_pick3
  import music_pkg::*;
(
  input  logic [NUM_SRC-1:0] act,
  input  logic [1:0]         rr_ptr,
  output logic               valid,
  output logic [1:0]         winner
);

  logic [3:0] act_pad;
  logic [1:0] idx;

  assign act_pad = {1'b0, act};

  // Scan from the farthest offset down so the closest active index wins.
  always_comb begin
    valid  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx = idx_inc(rr_ptr, 2'(k));
      if (act_pad[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Round-robin arbiter sharing one tone generator among two keypads and the demo sequencer.
module tone_arbiter
  import music_pkg::*;
#(
  parameter int unsigned MIN_HOLD   = 5_000_000,
  parameter int unsigned MAX_HOLD   = 50_000_000,
  parameter int unsigned GAP_CYCLES = 100_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic [3:0] note_in0,
  input  logic [3:0] note_in1,
  input  logic [3:0] note_in2,
  output logic [2:0] grant,
  output logic [1:0] owner_id,
  output logic [3:0] note_out,
  output logic       busy
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [HW-1:0] HoldMinLast = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0] HoldMaxLast = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HoldSat     = HW'(MAX_HOLD);
  localparam logic [GW-1:0] GapLast     = GW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    rr_q, rr_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    note_q, note_d;
  logic          busy_q, busy_d;

  logic [3:0] notes [4];
  logic [3:0] act_pad;
  logic       pick_valid;
  logic [1:0] pick_winner;
  logic       owner_act;
  logic       others_act;

  assign notes[0] = note_in0;
  assign notes[1] = note_in1;
  assign notes[2] = note_in2;
  assign notes[3] = NOTE_REST;

  assign act_pad = {1'b0,
                    req[2] && is_note(note_in2),
                    req[1] && is_note(note_in1),
                    req[0] && is_note(note_in0)};

  rr_pick3 u_pick (
    .act    (act_pad[2:0]),
    .rr_ptr (rr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign owner_act  = act_pad[owner_q];
  assign others_act = |(act_pad[2:0] & ~grant_q);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    owner_d = owner_q;
    note_d  = note_q;
    busy_d  = busy_q;

    if (!enable) begin
      state_d = StIdle;
      hold_d  = '0;
      gap_d   = '0;
      grant_d = 3'b000;
      owner_d = OWNER_NONE;
      note_d  = NOTE_REST;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_d = StPlay;
            hold_d  = '0;
            grant_d = 3'(3'b001 << pick_winner);
            owner_d = pick_winner;
            note_d  = notes[pick_winner];
            rr_d    = idx_inc(pick_winner, 2'd1);
            busy_d  = 1'b1;
          end
        end
        StPlay: begin
          hold_d = (hold_q == HoldSat) ? hold_q : hold_q + 1'b1;
          // Release takes priority over preemption; both lead to the gap.
          if ((!owner_act && hold_q >= HoldMinLast) ||
              (hold_q >= HoldMaxLast && others_act)) begin
            state_d = StGap;
            hold_d  = '0;
            gap_d   = '0;
            grant_d = 3'b000;
            owner_d = OWNER_NONE;
            note_d  = NOTE_REST;
          end else if (owner_act) begin
            note_d = notes[owner_q];
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_d = StIdle;
            gap_d   = '0;
            busy_d  = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          grant_d = 3'b000;
          owner_d = OWNER_NONE;
          note_d  = NOTE_REST;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      gap_q   <= '0;
      rr_q    <= 2'd0;
      grant_q <= 3'b000;
      owner_q <= OWNER_NONE;
      note_q  <= NOTE_REST;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign note_out = note_q;
  assign busy     = busy_q;

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
Shares one tone generator between three note sources: keypad player 1, keypad player 2, and the demo/song sequencer. It arbitrates round-robin, guarantees each granted note a minimum audible hold, and preempts long holds when another source is waiting. It inserts a silent gap between owners and drives one note code (1..12 = note, 15 = rest) to the downstream tone-period/PWM stage.

Parameters:
MIN_HOLD, 5_000_000, minimum cycles a grant is held (50 ms at 100 MHz); must be >=1 and <=MAX_HOLD.
MAX_HOLD, 50_000_000, cycles after which the owner is preempted if another source is active (0.5 s).
GAP_CYCLES, 100_000, silent cycles between owners (1 ms); must be >=1.

Ports:
sys_clk  in  1  clock, 100 MHz.
sys_rst_n  in  1  reset; asynchronous, active-low.
enable  in  1  arbiter enable; low forces silence.
req  in  3  per-source request (bit0 = P1, bit1 = P2, bit2 = demo).
note_in0  in  4  P1 note code.
note_in1  in  4  P2 note code.
note_in2  in  4  demo note code.
grant  out  3  one-hot current owner; 0 when none.
owner_id  out  2  owner index 0..2; 3 when none.
note_out  out  4  note to tone stage; 15 when silent.
busy  out  1  high in PLAY or GAP.

Behaviour:
- Active request: act[i] = req[i] && note_in[i] in 1..12. Codes 0, 13, 14 and 15 are treated as inactive.
- Reset values: state IDLE, grant 0, owner_id 3, note_out 15, busy 0, rr_ptr 0, hold_cnt 0, gap_cnt 0. All outputs are registered.
- IDLE:
  - If any act[i], pick the first active index scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Next cycle: state PLAY, grant/owner_id = winner, note_out = note_in[winner], hold_cnt = 0, rr_ptr = winner+1 mod 3.
  - Latency is one cycle from act to grant.
- PLAY, each cycle:
  - hold_cnt increments and saturates at MAX_HOLD.
  - Owner active: note_out follows the owner's note_in with one-cycle latency. A note change does not reset hold_cnt.
  - Owner inactive and hold_cnt < MIN_HOLD-1: note_out keeps its last value (the minimum hold is enforced).
  - Owner inactive and hold_cnt >= MIN_HOLD-1: go to GAP.
  - hold_cnt >= MAX_HOLD-1 and any non-owner active: go to GAP (preempt).
  - hold_cnt >= MAX_HOLD-1 and no other source active: stay in PLAY indefinitely.
  - If the owner releases and another source requests in the same cycle, release wins; go to GAP.
- GAP:
  - grant 0, owner_id 3, note_out 15, busy 1.
  - gap_cnt counts 0..GAP_CYCLES-1, then state goes to IDLE.
  - No arbitration happens during GAP. Requests are sampled in IDLE.
- enable low:
  - From any state, next cycle is IDLE with silent outputs; counters clear.
  - rr_ptr is preserved.
  - While enable is low, IDLE does not arbitrate.
- Asynchronous reset mid-PLAY: outputs go silent immediately.
- Fairness: a continuously active source is granted within 2 × (MAX_HOLD + GAP_CYCLES + 1) cycles.
- Counter widths are $clog2(MAX_HOLD+1) and $clog2(GAP_CYCLES+1). There is no wrap-around because hold_cnt saturates.

Decomposition:
- Shared package music_pkg holds:
  - NOTE_REST = 4'd15
  - NUM_SRC = 3
  - OWNER_NONE = 2'd3
  - state enum {IDLE, PLAY, GAP}
  - an is_note(code) function returning true for codes 1..12
- One sub-module, rr_pick3: combinational round-robin picker taking act[2:0] and rr_ptr, producing a valid flag and winner index.

Test Plan (MIN_HOLD=8, MAX_HOLD=20, GAP_CYCLES=3):
1. Reset, then P1 req with note 5 held 30 cycles -> grant=001 one cycle later; note_out=5; held to cycle 30; then 3 cycles at 15; then IDLE; all outputs at reset values during reset.
2. P2 note 7 pulsed 2 cycles -> note_out=7 for exactly 8 cycles; then GAP 3 cycles of 15.
3. P1 and P2 both active continuously from IDLE with rr_ptr=0 -> P1 granted 20 cycles, then GAP 3, then P2 granted, then P1 again.
4. All three requesting simultaneously after P2 last owned -> next grant goes to demo (100), then P1.
5. P1 owner changes note 3->9->1 mid-PLAY -> note_out tracks each change one cycle later; hold_cnt is not reset (preemption still happens at cycle 20 if P2 is waiting).
6. enable dropped mid-PLAY, or a note code 13 or 0 applied -> note_out=15 and grant=0 next cycle; code 13/0 never produces a grant.
